// File: rtl/spi_slave_fifo.sv
// SPI slave for all CPOL/CPHA modes with TX/RX valid-ready FIFOs, single i_clk domain.
// Define SPI_SLAVE_ERR_FLAGS_EN to build the sticky underflow/overflow flags.
module spi_slave_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_sclk,
  input  logic                          i_cs_n,
  input  logic                          i_mosi,
  output logic                          o_miso,
  output logic                          o_miso_oe,
  input  logic [DATA_WIDTH-1:0]         i_tx_data,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_tx_level,
  output logic [DATA_WIDTH-1:0]         o_rx_data,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_level,
  output logic                          o_busy,
  output logic                          o_frame_start,
  output logic                          o_frame_end,
  output logic                          o_tx_underflow,
  output logic                          o_rx_overflow
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned CW  = $clog2(DATA_WIDTH);
  localparam int unsigned MSB = DATA_WIDTH - 1;

  logic [2:0]            sclk_sync_q, sclk_sync_d;
  logic [2:0]            cs_sync_q, cs_sync_d;
  logic [1:0]            mosi_sync_q, mosi_sync_d;
  logic                  busy_q, busy_d;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_end_q, frame_end_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;

  logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] tx_mem_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_d [FIFO_DEPTH];
  logic [AW-1:0]         tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0]         rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [LW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;

  logic                  sclk_cur, sclk_prev, lead, trail;
  logic                  sample, load, shift, word_done;
  logic                  tx_push, tx_pop, rx_push, rx_pop;
  logic                  tx_unf_evt, rx_ovf_evt;
  logic [DATA_WIDTH-1:0] rx_word, tx_word, tx_shifted;

  // SCLK normalised so the leading edge is always a rising edge of sclk_cur
  assign sclk_cur  = sclk_sync_q[1] ^ CPOL;
  assign sclk_prev = sclk_sync_q[2] ^ CPOL;

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[1:0], i_sclk};
    cs_sync_d     = {cs_sync_q[1:0], i_cs_n};
    mosi_sync_d   = {mosi_sync_q[0], i_mosi};
    busy_d        = ~cs_sync_q[1];
    frame_start_d = ~cs_sync_q[1] & ~busy_q;
    frame_end_d   = cs_sync_q[1] & busy_q;

    lead  = busy_q & sclk_cur & ~sclk_prev;
    trail = busy_q & ~sclk_cur & sclk_prev;

    // Load points: CPHA=0 preloads at frame start and after each completed word
    if (CPHA) begin
      sample = trail;
      load   = lead && (bit_cnt_q == '0);
      shift  = lead && (bit_cnt_q != '0);
    end else begin
      sample = lead;
      load   = frame_start_q || (trail && (bit_cnt_q == '0));
      shift  = trail && (bit_cnt_q != '0);
    end

    if (MSB_FIRST) begin
      rx_word    = {rx_sh_q[MSB-1:0], mosi_sync_q[1]};
      tx_shifted = {tx_sh_q[MSB-1:0], 1'b0};
    end else begin
      rx_word    = {mosi_sync_q[1], rx_sh_q[MSB:1]};
      tx_shifted = {1'b0, tx_sh_q[MSB:1]};
    end
    word_done = sample && (bit_cnt_q == CW'(MSB));

    tx_push    = i_tx_valid & tx_ready_q;
    tx_pop     = load & (tx_cnt_q != '0);
    tx_unf_evt = load & (tx_cnt_q == '0);
    tx_word    = tx_pop ? tx_mem_q[tx_rd_q] : '0;

    rx_pop     = rx_valid_q & i_rx_ready;
    rx_push    = word_done & ((rx_cnt_q != LW'(FIFO_DEPTH)) | rx_pop);
    rx_ovf_evt = word_done & ~rx_push;

    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    // Inactive CS discards any partial word on both directions
    if (!busy_q) begin
      bit_cnt_d = '0;
      tx_sh_d   = '0;
      rx_sh_d   = '0;
    end else begin
      if (sample) begin
        rx_sh_d   = rx_word;
        bit_cnt_d = word_done ? '0 : bit_cnt_q + CW'(1);
      end
      if (load) begin
        tx_sh_d = tx_word;
      end else if (shift) begin
        tx_sh_d = tx_shifted;
      end
    end

    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q] = i_tx_data;
      tx_wr_d           = tx_wr_q + AW'(1);
    end
    if (tx_pop) begin
      tx_rd_d = tx_rd_q + AW'(1);
    end
    tx_cnt_d   = tx_cnt_q + LW'(tx_push) - LW'(tx_pop);
    tx_ready_d = (tx_cnt_d != LW'(FIFO_DEPTH));

    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = rx_word;
      rx_wr_d           = rx_wr_q + AW'(1);
    end
    if (rx_pop) begin
      rx_rd_d = rx_rd_q + AW'(1);
    end
    rx_cnt_d   = rx_cnt_q + LW'(rx_push) - LW'(rx_pop);
    rx_valid_d = (rx_cnt_d != '0);
    rx_data_d  = rx_mem_d[rx_rd_d];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync_q   <= {3{CPOL}};
      cs_sync_q     <= 3'b111;
      mosi_sync_q   <= '0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      bit_cnt_q     <= '0;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
      tx_cnt_q      <= '0;
      rx_cnt_q      <= '0;
      tx_ready_q    <= 1'b1;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      busy_q        <= busy_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      tx_mem_q      <= tx_mem_d;
      rx_mem_q      <= rx_mem_d;
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_ready_q    <= tx_ready_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
    end
  end

  assign o_miso        = busy_q ? (MSB_FIRST ? tx_sh_q[MSB] : tx_sh_q[0]) : 1'bz;
  assign o_miso_oe     = busy_q;
  assign o_busy        = busy_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_end   = frame_end_q;
  assign o_tx_ready    = tx_ready_q;
  assign o_tx_level    = tx_cnt_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_rx_data     = rx_data_q;
  assign o_rx_level    = rx_cnt_q;

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic tx_unf_q, tx_unf_d, rx_ovf_q, rx_ovf_d;

  // Sticky until frame start; an event in the frame-start cycle keeps the flag set
  always_comb begin
    tx_unf_d = (tx_unf_q & ~frame_start_q) | tx_unf_evt;
    rx_ovf_d = (rx_ovf_q & ~frame_start_q) | rx_ovf_evt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_unf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      tx_unf_q <= tx_unf_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end

  assign o_tx_underflow = tx_unf_q;
  assign o_rx_overflow  = rx_ovf_q;
`else
  logic unused_err_evt;
  assign unused_err_evt = tx_unf_evt | rx_ovf_evt;
  assign o_tx_underflow = 1'b0;
  assign o_rx_overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: mode-0 MSB-first and mode-3 LSB-first instances against a queue model.
module tb_spi_slave_fifo;

  localparam int H = 8;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sclk [2];
  logic       cs_n [2];
  logic       mosi [2];
  logic [7:0] tx_data [2];
  logic       tx_valid [2];
  logic       rx_ready [2];
  wire        miso0, miso1;
  logic       oe_w [2], tx_ready_w [2], rx_valid_w [2], busy_w [2];
  logic       fstart_w [2], fend_w [2], unf_w [2], ovf_w [2];
  logic [7:0] rx_data_w [2];
  logic [2:0] tx_level_w [2], rx_level_w [2];

  spi_slave_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_m0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk[0]), .i_cs_n(cs_n[0]), .i_mosi(mosi[0]),
    .o_miso(miso0), .o_miso_oe(oe_w[0]), .i_tx_data(tx_data[0]), .i_tx_valid(tx_valid[0]),
    .o_tx_ready(tx_ready_w[0]), .o_tx_level(tx_level_w[0]), .o_rx_data(rx_data_w[0]),
    .o_rx_valid(rx_valid_w[0]), .i_rx_ready(rx_ready[0]), .o_rx_level(rx_level_w[0]),
    .o_busy(busy_w[0]), .o_frame_start(fstart_w[0]), .o_frame_end(fend_w[0]),
    .o_tx_underflow(unf_w[0]), .o_rx_overflow(ovf_w[0]));

  spi_slave_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_m3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk[1]), .i_cs_n(cs_n[1]), .i_mosi(mosi[1]),
    .o_miso(miso1), .o_miso_oe(oe_w[1]), .i_tx_data(tx_data[1]), .i_tx_valid(tx_valid[1]),
    .o_tx_ready(tx_ready_w[1]), .o_tx_level(tx_level_w[1]), .o_rx_data(rx_data_w[1]),
    .o_rx_valid(rx_valid_w[1]), .i_rx_ready(rx_ready[1]), .o_rx_level(rx_level_w[1]),
    .o_busy(busy_w[1]), .o_frame_start(fstart_w[1]), .o_frame_end(fend_w[1]),
    .o_tx_underflow(unf_w[1]), .o_rx_overflow(ovf_w[1]));

  int n_chk = 0;
  int n_fail = 0;
  int fs_cnt [2] = '{0, 0};
  int fe_cnt [2] = '{0, 0};
  int fs_exp [2] = '{0, 0};
  int fe_exp [2] = '{0, 0};

  // Reference model: one queue per FIFO, sticky flags, word currently queued for MISO
  logic [7:0] txq0[$], txq1[$], rxq0[$], rxq1[$];
  logic       unf_m [2] = '{1'b0, 1'b0};
  logic       ovf_m [2] = '{1'b0, 1'b0};
  logic [7:0] cur_w [2] = '{8'h00, 8'h00};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fstart_w[i]) fs_cnt[i]++;
      if (fend_w[i]) fe_cnt[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int txsz(input int m);
    return (m == 0) ? txq0.size() : txq1.size();
  endfunction

  function automatic int rxsz(input int m);
    return (m == 0) ? rxq0.size() : rxq1.size();
  endfunction

  task automatic m_load(input int m, output logic [7:0] d);
    d = 8'h00;
    if (txsz(m) == 0) unf_m[m] = 1'b1;
    else if (m == 0) d = txq0.pop_front();
    else d = txq1.pop_front();
  endtask

  task automatic m_rx_push(input int m, input logic [7:0] d);
    if (rxsz(m) >= 4) ovf_m[m] = 1'b1;
    else if (m == 0) rxq0.push_back(d);
    else rxq1.push_back(d);
  endtask

  task automatic push_tx(input int m, input logic [7:0] d);
    @(negedge clk);
    chk("tx_ready", 32'(tx_ready_w[m]), 32'(txsz(m) < 4));
    tx_data[m]  = d;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
    if (txsz(m) < 4) begin
      if (m == 0) txq0.push_back(d);
      else txq1.push_back(d);
    end
    chk("tx_level_push", 32'(tx_level_w[m]), 32'(txsz(m)));
  endtask

  task automatic spi_bits(input int m, input logic [7:0] wd, input int nbits, output logic [7:0] got);
    logic cpol;
    int   b;
    cpol = (m == 1);
    got  = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      b = (m == 0) ? 7 - i : i;
      if (m == 0) begin
        mosi[m] = wd[b];
        repeat (H) @(negedge clk);
        got[b]  = miso0;
        sclk[m] = ~cpol;
        repeat (H) @(negedge clk);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = wd[b];
        repeat (H) @(negedge clk);
        got[b]  = miso1;
        sclk[m] = cpol;
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic cs_begin(input int m);
    fs_exp[m]++;
    unf_m[m] = 1'b0;
    ovf_m[m] = 1'b0;
    cs_n[m]  = 1'b0;
    if (m == 0) m_load(m, cur_w[m]);
    repeat (2 * H) @(negedge clk);
    chk("busy", 32'(busy_w[m]), 32'd1);
    chk("miso_oe", 32'(oe_w[m]), 32'd1);
  endtask

  task automatic cs_end(input int m);
    repeat (H) @(negedge clk);
    cs_n[m] = 1'b1;
    fe_exp[m]++;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic frame_word(input int m, input logic [7:0] wd);
    logic [7:0] expw, got;
    if (m == 1) m_load(m, expw);
    else expw = cur_w[m];
    spi_bits(m, wd, 8, got);
    chk("miso_word", 32'(got), 32'(expw));
    m_rx_push(m, wd);
    if (m == 0) m_load(m, cur_w[m]);
  endtask

  task automatic check_state(input int m);
    chk("tx_level", 32'(tx_level_w[m]), 32'(txsz(m)));
    chk("rx_level", 32'(rx_level_w[m]), 32'(rxsz(m)));
    chk("tx_ready", 32'(tx_ready_w[m]), 32'(txsz(m) < 4));
    chk("rx_valid", 32'(rx_valid_w[m]), 32'(rxsz(m) > 0));
    chk("tx_underflow", 32'(unf_w[m]), 32'(FLAGS & unf_m[m]));
    chk("rx_overflow", 32'(ovf_w[m]), 32'(FLAGS & ovf_m[m]));
    chk("frame_starts", 32'(fs_cnt[m]), 32'(fs_exp[m]));
    chk("frame_ends", 32'(fe_cnt[m]), 32'(fe_exp[m]));
  endtask

  task automatic rx_pop_chk(input int m);
    logic [7:0] d;
    @(negedge clk);
    chk("rx_valid_pop", 32'(rx_valid_w[m]), 32'(rxsz(m) > 0));
    if (rxsz(m) > 0) begin
      d = (m == 0) ? rxq0[0] : rxq1[0];
      chk("rx_data", 32'(rx_data_w[m]), 32'(d));
      rx_ready[m] = 1'b1;
      @(negedge clk);
      rx_ready[m] = 1'b0;
      if (m == 0) void'(rxq0.pop_front());
      else void'(rxq1.pop_front());
    end
  endtask

  task automatic model_reset();
    txq0.delete(); txq1.delete(); rxq0.delete(); rxq1.delete();
    for (int i = 0; i < 2; i++) begin
      unf_m[i] = 1'b0;
      ovf_m[i] = 1'b0;
      cur_w[i] = 8'h00;
    end
  endtask

  initial begin
    logic [7:0] got;
    int k, nw;
    sclk     = '{1'b0, 1'b1};
    cs_n     = '{1'b1, 1'b1};
    mosi     = '{1'b0, 1'b0};
    tx_data  = '{8'h00, 8'h00};
    tx_valid = '{1'b0, 1'b0};
    rx_ready = '{1'b0, 1'b0};
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Reset values
    for (int m = 0; m < 2; m++) begin
      check_state(m);
      chk("rx_data_rst", 32'(rx_data_w[m]), 32'd0);
      chk("busy_rst", 32'(busy_w[m]), 32'd0);
      chk("oe_rst", 32'(oe_w[m]), 32'd0);
    end

    // Mode 0 two-word burst
    push_tx(0, 8'hA5);
    push_tx(0, 8'h3C);
    cs_begin(0);
    frame_word(0, 8'h5A);
    frame_word(0, 8'hC3);
    cs_end(0);
    check_state(0);
    rx_pop_chk(0);
    rx_pop_chk(0);
    rx_pop_chk(0);

    // CPOL=1, CPHA=1, LSB first
    push_tx(1, 8'h81);
    cs_begin(1);
    frame_word(1, 8'h0F);
    cs_end(1);
    check_state(1);
    rx_pop_chk(1);

    // TX empty: zeros shifted out, underflow flagged
    cs_begin(0);
    frame_word(0, 8'h77);
    cs_end(0);
    check_state(0);
    rx_pop_chk(0);

    // RX full: fifth word dropped
    cs_begin(0);
    for (int i = 1; i <= 5; i++) frame_word(0, 8'(i));
    cs_end(0);
    check_state(0);
    for (int i = 0; i < 5; i++) rx_pop_chk(0);

    // CS abort after 3 bits, then a clean frame
    push_tx(0, 8'hF0);
    cs_begin(0);
    spi_bits(0, 8'hE7, 3, got);
    check_state(0);
    cs_end(0);
    check_state(0);
    cs_begin(0);
    frame_word(0, 8'h99);
    cs_end(0);
    check_state(0);
    rx_pop_chk(0);

    // Reset mid-word with both FIFOs at level 2
    cs_begin(0);
    frame_word(0, 8'h11);
    frame_word(0, 8'h22);
    cs_end(0);
    push_tx(0, 8'h31);
    push_tx(0, 8'h32);
    push_tx(0, 8'h33);
    cs_begin(0);
    spi_bits(0, 8'hAA, 3, got);
    check_state(0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_tx_level", 32'(tx_level_w[0]), 32'd0);
    chk("rst_rx_level", 32'(rx_level_w[0]), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid_w[0]), 32'd0);
    chk("rst_miso_oe", 32'(oe_w[0]), 32'd0);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    cs_n[0] = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_state(0);
    check_state(1);
    push_tx(0, 8'h5A);
    cs_begin(0);
    frame_word(0, 8'h3C);
    cs_end(0);
    check_state(0);
    rx_pop_chk(0);

    // Randomised frames on both instances
    for (int r = 0; r < 4; r++) begin
      for (int m = 0; m < 2; m++) begin
        k  = $urandom_range(0, 3);
        nw = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) push_tx(m, 8'($urandom));
        cs_begin(m);
        for (int i = 0; i < nw; i++) frame_word(m, 8'($urandom));
        cs_end(m);
        check_state(m);
        while (rxsz(m) > 0) rx_pop_chk(m);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
